pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central sequencing controller for the five-stage pipeline. It computes the enable, stall and clear strobes for the PC register and the four inter-stage registers (IF/ID, ID/EX, EX/DM, DM/WB) from the hazards each cycle. It handles:
- load-use interlock bubbles;
- branch-misprediction flushes;
- multi-cycle data-memory waits, counted down internally;
- halt/resume and single-step debug.

It also keeps stall and flush performance counters. All stage-register clears are active-low, matching the pipeline registers.

## Interface
Parameters:
- MEM_LAT, 0: extra freeze cycles per load/store held in EX/DM (0 to 15); 0 disables memory waits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
- ex_is_load  in  1  instruction in EX is a load.
- ex_w_en  in  1  instruction in EX writes the register file.
- ex_req_w  in  5  destination register of the EX instruction.
- ex_mispredict  in  1  EX branch/jump outcome differs from its guessed bit.
- dm_mem_op  in  1  EX/DM register holds a load or store.
- wb_halt  in  1  DM/WB register holds a halting syscall.
- step_mode  in  1  debug single-step mode.
- step  in  1  advance-one-cycle pulse, used when step_mode=1.
- resume  in  1  leave HALTED.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID enable.
- if_id_stall  out  1  IF/ID stall.
- if_id_clr_n  out  1  IF/ID clear, active-low.
- id_ex_en, id_ex_clr_n  out  1 each  ID/EX enable and clear.
- ex_dm_en, ex_dm_clr_n  out  1 each  EX/DM enable and clear.
- dm_wb_en, dm_wb_clr_n  out  1 each  DM/WB enable and clear.
- halted  out  1  high in HALTED.
- state  out  2  RUN=0, MEM_WAIT=1, HALTED=2.
- stall_cnt  out  32  cycles frozen or stalled.
- flush_cnt  out  32  number of misprediction flushes.

## Operation
- Strobes are combinational from the current state and inputs. State, the wait counter and the performance counters are registered.
- Strobe patterns:
  - NORMAL: pc_en and every *_en =1; if_id_stall=0; every clr_n=1.
  - FREEZE: pc_en and every *_en =0; if_id_stall=0; every clr_n=1.
  - BUBBLE: NORMAL except pc_en=0, if_id_stall=1, id_ex_clr_n=0.
  - FLUSH: NORMAL except if_id_clr_n=0 and id_ex_clr_n=0.
- An advancing cycle is one where step_mode=0, or where step_mode=1 and step=1.
- lu_hazard = ex_is_load & ex_w_en & (ex_req_w!=0) & ((id_use_rs & id_rs==ex_req_w) | (id_use_rt & id_rt==ex_req_w)).
- RUN, evaluated by priority:
  1. Non-advancing cycle: FREEZE, nothing counted.
  2. wb_halt: FREEZE, go to HALTED.
  3. dm_mem_op with MEM_LAT>0: FREEZE, load wait_cnt=MEM_LAT-1, go to MEM_WAIT.
  4. ex_mispredict: FLUSH, flush_cnt+1. This wins over lu_hazard because the ID instruction is wrong-path.
  5. lu_hazard: BUBBLE.
  6. Otherwise: NORMAL.
- MEM_WAIT:
  - Counts down every cycle regardless of step_mode.
  - wait_cnt!=0: FREEZE, wait_cnt-1.
  - wait_cnt==0: apply RUN rules 4-6, with the step gating of rule 1 and without rule 3, then go to RUN. If this cycle is non-advancing, stay in MEM_WAIT (FREEZE).
- HALTED:
  - FREEZE and halted=1.
  - resume=1: dm_wb_clr_n=0 (removes the halt, so it cannot re-trigger), go to RUN.
- stall_cnt increments on every FREEZE or BUBBLE cycle in RUN or MEM_WAIT, except non-advancing step cycles.
- Both counters wrap modulo 2^32.

## Timing
- While rst=1: pc_en=0, all *_en=0, if_id_stall=0, all clr_n=1, halted=0, state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0.
- Reset mid-MEM_WAIT or in HALTED returns to RUN at once and discards the wait.
- Load-use costs exactly one bubble cycle. The next cycle sees the load in DM, lu_hazard drops, and the pipeline resumes NORMAL.
- Misprediction flush takes effect in the same cycle: the redirect PC loads at that edge and the two youngest instructions are cleared.
- A memory op freezes for exactly MEM_LAT cycles; the pipeline advances on cycle MEM_LAT+1 after entry.
- Halt freeze begins in the cycle wb_halt is first seen; halted rises one cycle later.
- resume is ignored outside HALTED. RUN resumes one cycle after resume is sampled.

## Test plan
- Load-use: load writes r5 in EX, ID reads rs=5 with id_use_rs=1 -> one cycle with pc_en=0, if_id_stall=1, id_ex_clr_n=0; stall_cnt=1. Same setup with ex_req_w=0 -> NORMAL.
- Mispredict with lu_hazard in the same cycle -> FLUSH (if_id_clr_n=0, id_ex_clr_n=0, pc_en=1), no bubble; flush_cnt=1.
- MEM_LAT=3, dm_mem_op=1 -> 3 FREEZE cycles with state=1, NORMAL on the 4th, state=0; stall_cnt=3. MEM_LAT=0 -> no freeze.
- wb_halt=1 -> FREEZE, halted=1 next cycle. resume pulse 5 cycles later -> dm_wb_clr_n=0 for one cycle, then state=RUN, halted=0.
- step_mode=1, step pulsed every 4th cycle -> NORMAL only on pulse cycles, FREEZE otherwise, stall_cnt unchanged. With MEM_LAT=2 the wait still expires after 2 cycles, then waits for the next step pulse.
- Assert rst during MEM_WAIT (wait_cnt=1) and during HALTED -> outputs take reset values immediately without a clock edge; counters read 0 and state reads 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - five-stage pipeline sequencing controller
module pipeline_ctrl #(
   parameter int MEM_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        ex_is_load,
   input  logic        ex_w_en,
   input  logic [4:0]  ex_req_w,
   input  logic        ex_mispredict,
   input  logic        dm_mem_op,
   input  logic        wb_halt,
   input  logic        step_mode,
   input  logic        step,
   input  logic        resume,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_stall,
   output logic        if_id_clr_n,
   output logic        id_ex_en,
   output logic        id_ex_clr_n,
   output logic        ex_dm_en,
   output logic        ex_dm_clr_n,
   output logic        dm_wb_en,
   output logic        dm_wb_clr_n,
   output logic        halted,
   output logic [1:0]  state,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALTED   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      PAT_NORMAL,
      PAT_FREEZE,
      PAT_BUBBLE,
      PAT_FLUSH
   } pat_e;

   // The entry cycle is itself a freeze, so the countdown starts one short.
   localparam bit         MEM_WAIT_EN = (MEM_LAT > 0);
   localparam logic [3:0] WAIT_INIT   = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

   state_e      state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic [31:0] stall_q, stall_d;
   logic [31:0] flush_q, flush_d;
   pat_e        pat;
   logic        wb_clr;
   logic        resolve;
   logic        advance;
   logic        lu_hazard;

   assign advance   = ~step_mode | step;
   assign lu_hazard = ex_is_load & ex_w_en & (ex_req_w != 5'd0) &
                      ((id_use_rs & (id_rs == ex_req_w)) | (id_use_rt & (id_rt == ex_req_w)));

   // Next-state logic: pick the strobe pattern and update wait/perf counters.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      stall_d = stall_q;
      flush_d = flush_q;
      pat     = PAT_FREEZE;
      wb_clr  = 1'b0;
      resolve = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!advance) begin
               pat = PAT_FREEZE;
            end else if (wb_halt) begin
               stall_d = stall_q + 32'd1;
               state_d = ST_HALTED;
            end else if (MEM_WAIT_EN && dm_mem_op) begin
               stall_d = stall_q + 32'd1;
               wait_d  = WAIT_INIT;
               state_d = ST_MEM_WAIT;
            end else begin
               resolve = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // The memory latency elapses in real time, even while single-stepping.
            if (wait_q != 4'd0) begin
               wait_d = wait_q - 4'd1;
               if (advance) begin
                  stall_d = stall_q + 32'd1;
               end
            end else if (advance) begin
               resolve = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_HALTED: begin
            // Clearing DM/WB drops the halting syscall so it cannot re-trigger.
            if (resume) begin
               wb_clr  = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      // Mispredict outranks load-use: the ID instruction is on the wrong path.
      if (resolve) begin
         if (ex_mispredict) begin
            pat     = PAT_FLUSH;
            flush_d = flush_q + 32'd1;
         end else if (lu_hazard) begin
            pat     = PAT_BUBBLE;
            stall_d = stall_q + 32'd1;
         end else begin
            pat = PAT_NORMAL;
         end
      end
   end

   // Strobe decode; reset forces the frozen, non-clearing pattern.
   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_stall = 1'b0;
      if_id_clr_n = 1'b1;
      id_ex_en    = 1'b0;
      id_ex_clr_n = 1'b1;
      ex_dm_en    = 1'b0;
      ex_dm_clr_n = 1'b1;
      dm_wb_en    = 1'b0;
      dm_wb_clr_n = 1'b1;
      if (!rst) begin
         if (pat != PAT_FREEZE) begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            ex_dm_en = 1'b1;
            dm_wb_en = 1'b1;
         end
         if (pat == PAT_BUBBLE) begin
            pc_en       = 1'b0;
            if_id_stall = 1'b1;
            id_ex_clr_n = 1'b0;
         end
         if (pat == PAT_FLUSH) begin
            if_id_clr_n = 1'b0;
            id_ex_clr_n = 1'b0;
         end
         dm_wb_clr_n = ~wb_clr;
      end
   end

   // State, wait countdown and performance counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         wait_q  <= 4'd0;
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign halted    = (state_q == ST_HALTED) & ~rst;
   assign state     = state_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic       is_load;
      logic       w_en;
      logic [4:0] req_w;
      logic       misp;
      logic       mem_op;
      logic       halt;
      logic       step_mode;
      logic       step;
      logic       resume;
   } in_t;

   typedef struct packed {
      in_t        i;
      logic [9:0] exp;
   } vec_t;

   // {pc_en, if_id_en, if_id_stall, if_id_clr_n, id_ex_en, id_ex_clr_n, ex_dm_en, ex_dm_clr_n, dm_wb_en, dm_wb_clr_n}
   localparam logic [9:0] P_NORMAL = 10'b1101111111;
   localparam logic [9:0] P_FREEZE = 10'b0001010101;
   localparam logic [9:0] P_BUBBLE = 10'b0111101111;
   localparam logic [9:0] P_FLUSH  = 10'b1100101111;
   localparam logic [9:0] P_FRZCLR = 10'b0001010100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_req_w = '0;
   logic       id_use_rs = 0, id_use_rt = 0, ex_is_load = 0, ex_w_en = 0;
   logic       ex_mispredict = 0, dm_mem_op = 0, wb_halt = 0;
   logic       step_mode = 0, step = 0, resume = 0;

   logic [9:0]  strb [3];
   logic [1:0]  st   [3];
   logic        hl   [3];
   logic [31:0] sc   [3];
   logic [31:0] fc   [3];

   logic [9:0]  cap_strb [3];
   logic [1:0]  cap_st   [3];
   logic        cap_hl   [3];
   logic [31:0] cap_sc   [3];
   logic [31:0] cap_fc   [3];

   int          lat_of  [3] = '{3, 0, 2};
   int          m_mode  [3];
   int          m_frozen[3];
   logic [31:0] m_stall [3];
   logic [31:0] m_flush [3];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 3 : (g == 1) ? 0 : 2;
      logic pc_en, if_id_en, if_id_stall, if_id_clr_n, id_ex_en, id_ex_clr_n;
      logic ex_dm_en, ex_dm_clr_n, dm_wb_en, dm_wb_clr_n, halted;
      logic [1:0]  state;
      logic [31:0] stall_cnt, flush_cnt;
      pipeline_ctrl #(.MEM_LAT(LAT)) u_dut (
         .clk(clk), .rst(rst),
         .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
         .ex_is_load(ex_is_load), .ex_w_en(ex_w_en), .ex_req_w(ex_req_w),
         .ex_mispredict(ex_mispredict), .dm_mem_op(dm_mem_op), .wb_halt(wb_halt),
         .step_mode(step_mode), .step(step), .resume(resume),
         .pc_en(pc_en), .if_id_en(if_id_en), .if_id_stall(if_id_stall), .if_id_clr_n(if_id_clr_n),
         .id_ex_en(id_ex_en), .id_ex_clr_n(id_ex_clr_n), .ex_dm_en(ex_dm_en), .ex_dm_clr_n(ex_dm_clr_n),
         .dm_wb_en(dm_wb_en), .dm_wb_clr_n(dm_wb_clr_n), .halted(halted), .state(state),
         .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
      );
      assign strb[g] = {pc_en, if_id_en, if_id_stall, if_id_clr_n, id_ex_en, id_ex_clr_n,
                        ex_dm_en, ex_dm_clr_n, dm_wb_en, dm_wb_clr_n};
      assign st[g] = state;
      assign hl[g] = halted;
      assign sc[g] = stall_cnt;
      assign fc[g] = flush_cnt;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic in_t idle();
      in_t v;
      v = '0;
      return v;
   endfunction

   task automatic drive(input in_t v);
      id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
      ex_is_load = v.is_load; ex_w_en = v.w_en; ex_req_w = v.req_w;
      ex_mispredict = v.misp; dm_mem_op = v.mem_op; wb_halt = v.halt;
      step_mode = v.step_mode; step = v.step; resume = v.resume;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_mode[k] = 0; m_frozen[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
      end
   endtask

   // Reference behaviour: mode 0 run, 1 memory wait, 2 halted; m_frozen counts
   // memory-freeze cycles already spent against the latency.
   task automatic model_step(input int k, input in_t v, output logic [9:0] pat);
      bit adv, lu;
      adv = !v.step_mode || v.step;
      lu  = v.is_load && v.w_en && (v.req_w != 0) &&
            ((v.use_rs && v.rs == v.req_w) || (v.use_rt && v.rt == v.req_w));
      pat = P_FREEZE;
      if (m_mode[k] == 2) begin
         if (v.resume) begin
            pat = P_FRZCLR;
            m_mode[k] = 0;
         end
      end else if (m_mode[k] == 1 && m_frozen[k] < lat_of[k]) begin
         m_frozen[k]++;
         if (adv) m_stall[k]++;
      end else if (!adv) begin
         pat = P_FREEZE;
      end else if (m_mode[k] == 0 && v.halt) begin
         m_stall[k]++;
         m_mode[k] = 2;
      end else if (m_mode[k] == 0 && v.mem_op && lat_of[k] > 0) begin
         m_stall[k]++;
         m_mode[k] = 1;
         m_frozen[k] = 1;
      end else begin
         m_mode[k] = 0;
         if (v.misp) begin
            pat = P_FLUSH;
            m_flush[k]++;
         end else if (lu) begin
            pat = P_BUBBLE;
            m_stall[k]++;
         end else begin
            pat = P_NORMAL;
         end
      end
   endtask

   // Called at a falling edge: drive, sample mid-low-phase, step model, advance.
   task automatic run_cycle(input in_t v, input string name);
      logic [9:0] pat;
      drive(v);
      #2;
      for (int k = 0; k < 3; k++) begin
         cap_strb[k] = strb[k]; cap_st[k] = st[k]; cap_hl[k] = hl[k];
         cap_sc[k] = sc[k]; cap_fc[k] = fc[k];
         chk($sformatf("%s i%0d state", name, k), {30'd0, st[k]}, m_mode[k]);
         chk($sformatf("%s i%0d halted", name, k), {31'd0, hl[k]}, {31'd0, m_mode[k] == 2});
         chk($sformatf("%s i%0d stall_cnt", name, k), sc[k], m_stall[k]);
         chk($sformatf("%s i%0d flush_cnt", name, k), fc[k], m_flush[k]);
         model_step(k, v, pat);
         chk($sformatf("%s i%0d strobes", name, k), {22'd0, strb[k]}, {22'd0, pat});
      end
      @(negedge clk);
   endtask

   // Called at a falling edge: assert reset between edges and check it acts at once.
   task automatic do_reset(input string name);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s i%0d rst strobes", name, k), {22'd0, strb[k]}, {22'd0, P_FREEZE});
         chk($sformatf("%s i%0d rst state", name, k), {30'd0, st[k]}, 32'd0);
         chk($sformatf("%s i%0d rst halted", name, k), {31'd0, hl[k]}, 32'd0);
         chk($sformatf("%s i%0d rst stall", name, k), sc[k], 32'd0);
         chk($sformatf("%s i%0d rst flush", name, k), fc[k], 32'd0);
      end
      drive(idle());
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      vec_t tbl [11];
      in_t  v;

      v = idle();                                                    tbl[0]  = '{i: v, exp: P_NORMAL};
      v = idle(); v.is_load = 1; v.w_en = 1; v.req_w = 5; v.rs = 5; v.use_rs = 1;
                                                                     tbl[1]  = '{i: v, exp: P_BUBBLE};
      v = idle(); v.is_load = 1; v.w_en = 1; v.req_w = 9; v.rt = 9; v.use_rt = 1;
                                                                     tbl[2]  = '{i: v, exp: P_BUBBLE};
      v = tbl[1].i; v.use_rs = 0;                                    tbl[3]  = '{i: v, exp: P_NORMAL};
      v = tbl[1].i; v.is_load = 0;                                   tbl[4]  = '{i: v, exp: P_NORMAL};
      v = tbl[1].i; v.w_en = 0;                                      tbl[5]  = '{i: v, exp: P_NORMAL};
      v = tbl[1].i; v.req_w = 0; v.rs = 0;                           tbl[6]  = '{i: v, exp: P_NORMAL};
      v = idle(); v.misp = 1;                                        tbl[7]  = '{i: v, exp: P_FLUSH};
      v = tbl[1].i; v.misp = 1;                                      tbl[8]  = '{i: v, exp: P_FLUSH};
      v = idle(); v.resume = 1;                                      tbl[9]  = '{i: v, exp: P_NORMAL};
      v = tbl[1].i; v.rs = 6;                                        tbl[10] = '{i: v, exp: P_NORMAL};

      drive(idle());
      model_reset();
      @(negedge clk);
      do_reset("init");

      // Single-cycle vectors from RUN.
      for (int n = 0; n < 11; n++) begin
         run_cycle(tbl[n].i, $sformatf("tbl%0d", n));
         chk($sformatf("tbl%0d pattern", n), {22'd0, cap_strb[0]}, {22'd0, tbl[n].exp});
      end

      // Load-use: one bubble, then normal.
      do_reset("lu");
      run_cycle(tbl[1].i, "lu0");
      chk("lu bubble", {22'd0, cap_strb[0]}, {22'd0, P_BUBBLE});
      run_cycle(idle(), "lu1");
      chk("lu after", {22'd0, cap_strb[0]}, {22'd0, P_NORMAL});
      chk("lu stall_cnt", cap_sc[0], 32'd1);

      // Mispredict with simultaneous load-use.
      do_reset("mp");
      run_cycle(tbl[8].i, "mp0");
      chk("mp flush", {22'd0, cap_strb[0]}, {22'd0, P_FLUSH});
      run_cycle(idle(), "mp1");
      chk("mp flush_cnt", cap_fc[0], 32'd1);
      chk("mp stall_cnt", cap_sc[0], 32'd0);

      // Memory wait: MEM_LAT=3 on i0, MEM_LAT=0 on i1.
      do_reset("mem");
      v = idle(); v.mem_op = 1;
      for (int c = 0; c < 4; c++) begin
         run_cycle(v, $sformatf("mem%0d", c));
         chk($sformatf("mem%0d lat3", c), {22'd0, cap_strb[0]}, {22'd0, (c < 3) ? P_FREEZE : P_NORMAL});
         chk($sformatf("mem%0d lat0", c), {22'd0, cap_strb[1]}, {22'd0, P_NORMAL});
         if (c > 0) chk($sformatf("mem%0d state", c), {30'd0, cap_st[0]}, 32'd1);
      end
      run_cycle(idle(), "mem4");
      chk("mem end state", {30'd0, cap_st[0]}, 32'd0);
      chk("mem stall_cnt", cap_sc[0], 32'd3);

      // Halt, resume five cycles later.
      do_reset("halt");
      v = idle(); v.halt = 1;
      run_cycle(v, "halt0");
      chk("halt freeze", {22'd0, cap_strb[0]}, {22'd0, P_FREEZE});
      chk("halt not yet", {31'd0, cap_hl[0]}, 32'd0);
      for (int c = 1; c < 5; c++) begin
         run_cycle(v, $sformatf("halt%0d", c));
         chk($sformatf("halt%0d halted", c), {31'd0, cap_hl[0]}, 32'd1);
      end
      v.resume = 1;
      run_cycle(v, "halt5");
      chk("resume clr", {22'd0, cap_strb[0]}, {22'd0, P_FRZCLR});
      run_cycle(idle(), "halt6");
      chk("resume state", {30'd0, cap_st[0]}, 32'd0);
      chk("resume halted", {31'd0, cap_hl[0]}, 32'd0);
      chk("resume normal", {22'd0, cap_strb[0]}, {22'd0, P_NORMAL});

      // Single-step.
      do_reset("step");
      for (int c = 0; c < 8; c++) begin
         v = idle(); v.step_mode = 1; v.step = (c % 4 == 3);
         run_cycle(v, $sformatf("step%0d", c));
         chk($sformatf("step%0d pat", c), {22'd0, cap_strb[0]}, {22'd0, (c % 4 == 3) ? P_NORMAL : P_FREEZE});
      end
      for (int c = 0; c < 4; c++) begin
         v = idle(); v.step_mode = 1; v.mem_op = 1; v.step = (c == 0 || c == 3);
         run_cycle(v, $sformatf("smem%0d", c));
         if (c == 0) chk("step stall_cnt", cap_sc[2], 32'd0);
         chk($sformatf("smem%0d lat2", c), {22'd0, cap_strb[2]}, {22'd0, (c == 3) ? P_NORMAL : P_FREEZE});
      end
      run_cycle(idle(), "smem4");
      chk("smem state", {30'd0, cap_st[2]}, 32'd0);
      chk("smem stall_cnt", cap_sc[2], 32'd1);

      // Asynchronous reset in MEM_WAIT and in HALTED.
      do_reset("rw");
      v = idle(); v.mem_op = 1;
      run_cycle(v, "rw0");
      run_cycle(v, "rw1");
      do_reset("mid_wait");
      run_cycle(idle(), "rw2");
      chk("post wait reset", {22'd0, cap_strb[0]}, {22'd0, P_NORMAL});
      v = idle(); v.halt = 1;
      run_cycle(v, "rh0");
      run_cycle(v, "rh1");
      chk("pre reset halted", {31'd0, cap_hl[0]}, 32'd1);
      do_reset("mid_halt");

      // Randomized traffic against the reference model.
      for (int c = 0; c < 600; c++) begin
         v = idle();
         v.rs = 5'($urandom_range(0, 3));
         v.rt = 5'($urandom_range(0, 3));
         v.req_w = 5'($urandom_range(0, 3));
         v.use_rs = 1'($urandom_range(0, 1));
         v.use_rt = 1'($urandom_range(0, 1));
         v.is_load = 1'($urandom_range(0, 1));
         v.w_en = ($urandom_range(0, 3) != 0);
         v.misp = ($urandom_range(0, 5) == 0);
         v.mem_op = ($urandom_range(0, 4) == 0);
         v.halt = ($urandom_range(0, 24) == 0);
         v.resume = ($urandom_range(0, 3) == 0);
         v.step_mode = ((c / 50) % 3 == 2);
         v.step = ($urandom_range(0, 2) == 0);
         run_cycle(v, $sformatf("rnd%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
